// File: rtl/kv_lut_table_pkg.sv
// Shared opcodes and width helpers for the key/value lut table.
package kv_lut_table_pkg;

  localparam logic [1:0] OP_INSERT = 2'b00;
  localparam logic [1:0] OP_DELETE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  // Width of one packed {key,data} entry in the lut image.
  function automatic int unsigned pair_len(input int unsigned key_len,
                                           input int unsigned data_len);
    return key_len + data_len;
  endfunction

endpackage

// File: rtl/kv_lut_match.sv
// Combinational key compare: one-hot hit vector, any-hit, and lowest free entry.
module kv_lut_match #(
  parameter int unsigned NR_KEY  = 4,
  parameter int unsigned KEY_LEN = 7,
  parameter int unsigned IDX_W   = $clog2(NR_KEY)
) (
  input  logic [NR_KEY-1:0][KEY_LEN-1:0] keys,
  input  logic [NR_KEY-1:0]              valid,
  input  logic [KEY_LEN-1:0]             key,
  output logic [NR_KEY-1:0]              hit_vec,
  output logic                           any_hit,
  output logic [IDX_W-1:0]               free_idx,
  output logic                           any_free
);

  // Scan high-to-low so the last assignment leaves the lowest invalid index.
  always_comb begin
    hit_vec  = '0;
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      hit_vec[i] = valid[i] && (keys[i] == key);
      if (!valid[i]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
    any_hit = |hit_vec;
  end

endmodule

// File: rtl/muxwithdefault.sv
// Key-addressed select over a packed {key,data} lut image, returning a default on no match.
module muxwithdefault #(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 7,
  parameter int unsigned DATA_LEN = 32
) (
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  def_data,
  output logic [DATA_LEN-1:0]                  data
);

  localparam int unsigned PAIR = KEY_LEN + DATA_LEN;

  logic [PAIR-1:0]     pair;
  logic [DATA_LEN-1:0] data_or;
  logic                any_match;

  // OR-combine matching entries: zeroed invalid entries sharing a key of 0
  // contribute nothing, so a single valid match always wins.
  always_comb begin
    pair      = '0;
    data_or   = '0;
    any_match = 1'b0;
    for (int n = 0; n < NR_KEY; n++) begin
      pair = lut[n*PAIR +: PAIR];
      if (pair[PAIR-1 -: KEY_LEN] == key) begin
        any_match = 1'b1;
        data_or   = data_or | pair[DATA_LEN-1:0];
      end
    end
    data = any_match ? data_or : def_data;
  end

endmodule

// File: rtl/kv_lut_table.sv
// Registered key/value table owning the packed {key,data} lut image, with
// insert/delete/clear writes and a one-cycle registered lookup.
module kv_lut_table
  import kv_lut_table_pkg::*;
#(
  parameter int unsigned NR_KEY   = 4,
  parameter int unsigned KEY_LEN  = 7,
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_valid,
  input  logic [1:0]                           wr_op,
  input  logic [KEY_LEN-1:0]                   wr_key,
  input  logic [DATA_LEN-1:0]                  wr_data,
  output logic                                 wr_ack,
  output logic                                 wr_evict,
  input  logic                                 lk_valid,
  input  logic [KEY_LEN-1:0]                   lk_key,
  input  logic [DATA_LEN-1:0]                  lk_default,
  output logic                                 lk_rvalid,
  output logic                                 lk_hit,
  output logic [DATA_LEN-1:0]                  lk_rdata,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  output logic [$clog2(NR_KEY+1)-1:0]          count,
  output logic                                 full
);

  localparam int unsigned PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);
  localparam int unsigned PTR_W    = $clog2(NR_KEY);
  localparam int unsigned CNT_W    = $clog2(NR_KEY + 1);

  logic [NR_KEY-1:0]               valid_q, valid_d;
  logic [NR_KEY-1:0][KEY_LEN-1:0]  key_q, key_d;
  logic [NR_KEY-1:0][DATA_LEN-1:0] data_q, data_d;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]                count_q, count_d;

  logic                            wr_ack_q, wr_evict_q, wr_evict_d;
  logic                            lk_rvalid_q, lk_hit_q;
  logic [DATA_LEN-1:0]             lk_rdata_q, lk_rdata_d;

  logic [NR_KEY-1:0]               wr_hit_vec, lk_hit_vec;
  logic                            wr_any_hit, lk_any_hit;
  logic [PTR_W-1:0]                wr_free_idx, lk_free_idx;
  logic                            wr_any_free, lk_any_free;
  logic [DATA_LEN-1:0]             lk_mux_data;
  logic                            full_int;

  // Lookup side never allocates, so its free-slot outputs are deliberately dropped.
  logic unused_lk_free;
  assign unused_lk_free = ^{lk_free_idx, lk_any_free};

  kv_lut_match #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .IDX_W   (PTR_W)
  ) u_wr_match (
    .keys     (key_q),
    .valid    (valid_q),
    .key      (wr_key),
    .hit_vec  (wr_hit_vec),
    .any_hit  (wr_any_hit),
    .free_idx (wr_free_idx),
    .any_free (wr_any_free)
  );

  kv_lut_match #(
    .NR_KEY  (NR_KEY),
    .KEY_LEN (KEY_LEN),
    .IDX_W   (PTR_W)
  ) u_lk_match (
    .keys     (key_q),
    .valid    (valid_q),
    .key      (lk_key),
    .hit_vec  (lk_hit_vec),
    .any_hit  (lk_any_hit),
    .free_idx (lk_free_idx),
    .any_free (lk_any_free)
  );

  muxwithdefault #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_lk_mux (
    .lut      (lut),
    .key      (lk_key),
    .def_data (lk_default),
    .data     (lk_mux_data)
  );

  assign full_int = (count_q == CNT_W'(NR_KEY));

  // Packed image: invalid entries are forced to zero key and data.
  always_comb begin
    lut = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      lut[n*PAIR_LEN +: PAIR_LEN] = valid_q[n] ? {key_q[n], data_q[n]} : '0;
    end
  end

  // Table next-state for insert/delete/clear.
  always_comb begin
    valid_d    = valid_q;
    key_d      = key_q;
    data_d     = data_q;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    wr_evict_d = 1'b0;
    if (wr_valid) begin
      unique case (wr_op)
        OP_INSERT: begin
          if (wr_any_hit) begin
            for (int i = 0; i < NR_KEY; i++) begin
              if (wr_hit_vec[i]) data_d[i] = wr_data;
            end
          end else if (wr_any_free) begin
            valid_d[wr_free_idx] = 1'b1;
            key_d[wr_free_idx]   = wr_key;
            data_d[wr_free_idx]  = wr_data;
            count_d              = count_q + CNT_W'(1);
          end else begin
            // Table full: replace round-robin victim; count is unchanged.
            key_d[rr_ptr_q]  = wr_key;
            data_d[rr_ptr_q] = wr_data;
            wr_evict_d       = 1'b1;
            rr_ptr_d         = (rr_ptr_q == PTR_W'(NR_KEY - 1)) ? '0 : rr_ptr_q + PTR_W'(1);
          end
        end
        OP_DELETE: begin
          if (wr_any_hit) begin
            for (int i = 0; i < NR_KEY; i++) begin
              if (wr_hit_vec[i]) begin
                valid_d[i] = 1'b0;
                key_d[i]   = '0;
                data_d[i]  = '0;
              end
            end
            count_d = count_q - CNT_W'(1);
          end
        end
        OP_CLEAR: begin
          valid_d  = '0;
          key_d    = '0;
          data_d   = '0;
          rr_ptr_d = '0;
          count_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // Lookup result: hit data or the caller's default; holds when idle.
  always_comb begin
    lk_rdata_d = lk_rdata_q;
    if (lk_valid) lk_rdata_d = lk_any_hit ? lk_mux_data : lk_default;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      key_q       <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      wr_evict_q  <= 1'b0;
      lk_rvalid_q <= 1'b0;
      lk_hit_q    <= 1'b0;
      lk_rdata_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      key_q       <= key_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_valid;
      wr_evict_q  <= wr_evict_d;
      lk_rvalid_q <= lk_valid;
      lk_hit_q    <= lk_valid && lk_any_hit;
      lk_rdata_q  <= lk_rdata_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign wr_evict  = wr_evict_q;
  assign lk_rvalid = lk_rvalid_q;
  assign lk_hit    = lk_hit_q;
  assign lk_rdata  = lk_rdata_q;
  assign count     = count_q;
  assign full      = full_int;

endmodule

// File: tb/tb_kv_lut_table.sv
// Directed bench for kv_lut_table with an array-based reference model.
module tb_kv_lut_table;

  localparam int NK = 4;
  localparam int KL = 7;
  localparam int DL = 32;
  localparam int PL = KL + DL;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [1:0]        wr_op;
  logic [KL-1:0]     wr_key;
  logic [DL-1:0]     wr_data;
  logic              wr_ack, wr_evict;
  logic              lk_valid;
  logic [KL-1:0]     lk_key;
  logic [DL-1:0]     lk_default;
  logic              lk_rvalid, lk_hit;
  logic [DL-1:0]     lk_rdata;
  logic [NK*PL-1:0]  lut;
  logic [2:0]        count;
  logic              full;

  kv_lut_table #(
    .NR_KEY   (NK),
    .KEY_LEN  (KL),
    .DATA_LEN (DL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_op      (wr_op),
    .wr_key     (wr_key),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_evict   (wr_evict),
    .lk_valid   (lk_valid),
    .lk_key     (lk_key),
    .lk_default (lk_default),
    .lk_rvalid  (lk_rvalid),
    .lk_hit     (lk_hit),
    .lk_rdata   (lk_rdata),
    .lut        (lut),
    .count      (count),
    .full       (full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain slot table plus expected registered outputs.
  bit          m_valid [NK];
  int unsigned m_key   [NK];
  int unsigned m_data  [NK];
  int          m_rr;
  int          m_count;
  bit          e_ack, e_evict, e_rvalid, e_hit;
  logic [DL-1:0] e_rdata;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NK; i++) begin
      m_valid[i] = 0; m_key[i] = 0; m_data[i] = 0;
    end
    m_rr = 0; m_count = 0;
    e_ack = 0; e_evict = 0; e_rvalid = 0; e_hit = 0; e_rdata = '0;
  endfunction

  function automatic int find_key(input int unsigned k);
    for (int i = 0; i < NK; i++) if (m_valid[i] && m_key[i] == k) return i;
    return -1;
  endfunction

  function automatic logic [NK*PL-1:0] model_lut();
    logic [NK*PL-1:0] img = '0;
    logic [KL-1:0] k;
    logic [DL-1:0] d;
    for (int i = 0; i < NK; i++) begin
      if (m_valid[i]) begin
        k = KL'(m_key[i]);
        d = DL'(m_data[i]);
        img[i*PL +: PL] = {k, d};
      end
    end
    return img;
  endfunction

  // One clock of table semantics: lookup sees the table before the write.
  task automatic model_step();
    int idx;
    e_rvalid = lk_valid;
    e_hit    = 0;
    if (lk_valid) begin
      idx = find_key(lk_key);
      e_hit   = (idx >= 0);
      e_rdata = (idx >= 0) ? DL'(m_data[idx]) : lk_default;
    end
    e_ack   = wr_valid;
    e_evict = 0;
    if (wr_valid) begin
      case (wr_op)
        2'b00: begin
          idx = find_key(wr_key);
          if (idx >= 0) m_data[idx] = wr_data;
          else if (m_count < NK) begin
            for (int i = 0; i < NK; i++) begin
              if (!m_valid[i]) begin
                m_valid[i] = 1; m_key[i] = wr_key; m_data[i] = wr_data; m_count++;
                break;
              end
            end
          end else begin
            m_key[m_rr] = wr_key; m_data[m_rr] = wr_data;
            e_evict = 1;
            m_rr = (m_rr + 1) % NK;
          end
        end
        2'b01: begin
          idx = find_key(wr_key);
          if (idx >= 0) begin
            m_valid[idx] = 0; m_key[idx] = 0; m_data[idx] = 0; m_count--;
          end
        end
        2'b10: begin
          for (int i = 0; i < NK; i++) begin
            m_valid[i] = 0; m_key[i] = 0; m_data[i] = 0;
          end
          m_rr = 0; m_count = 0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("wr_ack", 256'(wr_ack), 256'(e_ack));
    chk("wr_evict", 256'(wr_evict), 256'(e_evict));
    chk("lk_rvalid", 256'(lk_rvalid), 256'(e_rvalid));
    chk("lk_hit", 256'(lk_hit), 256'(e_hit));
    chk("lk_rdata", 256'(lk_rdata), 256'(e_rdata));
    chk("count", 256'(count), 256'(m_count));
    chk("full", 256'(full), 256'(m_count == NK));
    chk("lut", 256'(lut), 256'(model_lut()));
  endtask

  // Drive one cycle of stimulus from a negedge, then compare at the next negedge.
  task automatic cyc(input bit wv, input logic [1:0] op, input int unsigned wk,
                     input int unsigned wd, input bit lv, input int unsigned lk,
                     input int unsigned ld);
    wr_valid = wv; wr_op = op; wr_key = KL'(wk); wr_data = DL'(wd);
    lk_valid = lv; lk_key = KL'(lk); lk_default = DL'(ld);
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic ins(input int unsigned k, input int unsigned d);
    cyc(1, 2'b00, k, d, 0, 0, 0);
  endtask

  task automatic look(input int unsigned k, input int unsigned dflt);
    cyc(0, 2'b00, 0, 0, 1, k, dflt);
  endtask

  initial begin
    rst = 1'b1;
    wr_valid = 0; wr_op = 0; wr_key = 0; wr_data = 0;
    lk_valid = 0; lk_key = 0; lk_default = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    chk("reset_lut", 256'(lut), 256'(0));
    rst = 1'b0;

    // 1: insert then lookup
    ins(5, 32'h11);
    chk("t1_ack", 256'(wr_ack), 256'(1));
    chk("t1_count", 256'(count), 256'(1));
    look(5, 32'hDEAD);
    chk("t1_hit", 256'(lk_hit), 256'(1));
    chk("t1_rdata", 256'(lk_rdata), 256'(32'h11));

    // 2: miss returns default
    look(9, 32'hDEAD);
    chk("t2_hit", 256'(lk_hit), 256'(0));
    chk("t2_rdata", 256'(lk_rdata), 256'(32'hDEAD));

    // 3: update in place
    ins(5, 32'h22);
    chk("t3_count", 256'(count), 256'(1));
    chk("t3_evict", 256'(wr_evict), 256'(0));
    look(5, 32'hDEAD);
    chk("t3_rdata", 256'(lk_rdata), 256'(32'h22));

    // 4: fill then evict round-robin through a full wrap
    cyc(1, 2'b10, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) ins(k, 32'h100 + k);
    chk("t4_full", 256'(full), 256'(1));
    ins(7'h7F, 32'h33);
    chk("t4_evict1", 256'(wr_evict), 256'(1));
    chk("t4_slot0_key", 256'(lut[PL-1 -: KL]), 256'(7'h7F));
    look(1, 32'hBEEF);
    chk("t4_key1_gone", 256'(lk_rdata), 256'(32'hBEEF));
    ins(7'h7E, 32'h34);
    look(2, 32'hBEEF);
    chk("t4_key2_gone", 256'(lk_hit), 256'(0));
    ins(7'h7D, 32'h35);
    ins(7'h7C, 32'h36);
    ins(7'h7B, 32'h37);
    look(7'h7F, 32'hBEEF);
    chk("t4_wrap_7F_gone", 256'(lk_hit), 256'(0));
    look(7'h7B, 32'hBEEF);
    chk("t4_wrap_7B", 256'(lk_rdata), 256'(32'h37));
    chk("t4_count", 256'(count), 256'(4));

    // 5: read-before-write on the same key
    cyc(1, 2'b10, 0, 0, 0, 0, 0);
    ins(3, 32'h10);
    cyc(1, 2'b00, 3, 32'h44, 1, 3, 32'hDEAD);
    chk("t5_old", 256'(lk_rdata), 256'(32'h10));
    look(3, 32'hDEAD);
    chk("t5_new", 256'(lk_rdata), 256'(32'h44));

    // 6: delete hit/miss, clear when full, reserved op
    ins(6, 32'h55);
    cyc(1, 2'b01, 3, 0, 0, 0, 0);
    chk("t6_del_hit", 256'(count), 256'(1));
    cyc(1, 2'b01, 3, 0, 0, 0, 0);
    chk("t6_del_miss", 256'(count), 256'(1));
    ins(8, 1); ins(9, 2); ins(10, 3);
    chk("t6_full", 256'(full), 256'(1));
    cyc(1, 2'b11, 8, 32'h99, 0, 0, 0);
    chk("t6_rsv_ack", 256'(wr_ack), 256'(1));
    chk("t6_rsv_count", 256'(count), 256'(4));
    cyc(1, 2'b10, 0, 0, 0, 0, 0);
    chk("t6_clr_count", 256'(count), 256'(0));
    chk("t6_clr_full", 256'(full), 256'(0));

    // Reset in the middle of a lookup stream
    ins(1, 32'h77);
    lk_valid = 1; lk_key = 1; lk_default = 0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_rvalid", 256'(lk_rvalid), 256'(0));
    chk("rst_rdata", 256'(lk_rdata), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    model_reset();
    lk_valid = 0;
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    look(1, 32'hCAFE);
    chk("post_rst_miss", 256'(lk_rdata), 256'(32'hCAFE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
